// File: rtl/alu_req_ctrl_if.sv
// rtl/alu_req_ctrl_if.sv - request/response handshake bundle for the ALU requester
interface alu_req_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_a;
  logic [63:0]  req_b;
  logic [1:0]   req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_req_ctrl.sv
// rtl/alu_req_ctrl.sv - requester controller driving the pipelined 64-bit ALU
module alu_req_ctrl #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  alu_req_ctrl_if.slave     bus,
  output logic [63:0]       alu_a,
  output logic [63:0]       alu_b,
  output logic [1:0]        alu_op,
  input  logic [127:0]      alu_c,
  input  logic              alu_completed,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] op_q;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= 2'd0;
      wait_cnt      <= 8'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= 2'd0;
      busy          <= 1'b0;
      op_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            if (bus.req_op != 2'd0) begin
              alu_a  <= bus.req_a;
              alu_b  <= bus.req_b;
              alu_op <= bus.req_op;
              op_q   <= bus.req_op;
              state  <= ISSUE;
            end else begin
              // nop never touches the ALU and answers immediately
              bus.rsp_data  <= '0;
              bus.rsp_err   <= 1'b0;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end
          end
        end
        ISSUE: begin
          alu_op   <= 2'd0;
          wait_cnt <= 8'd0;
          state    <= WAIT;
        end
        WAIT: begin
          // completion is checked first so it beats a coincident timeout
          if (alu_completed) begin
            bus.rsp_data  <= alu_c;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            wait_cnt      <= 8'd0;
            state         <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            wait_cnt      <= 8'd0;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
            if (!bus.rsp_err) op_count <= op_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_ctrl.sv
// tb/tb_alu_req_ctrl.sv - directed bench for alu_req_ctrl with a behavioural ALU
module tb_alu_req_ctrl;
  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  alu_a, alu_b;
  logic [1:0]   alu_op;
  logic [127:0] alu_c;
  logic         alu_completed;
  logic         busy;
  logic [15:0]  op_count;

  int n_vec = 0;
  int n_err = 0;

  alu_req_ctrl_if bus();

  alu_req_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_c         (alu_c),
    .alu_completed (alu_completed),
    .busy          (busy),
    .op_count      (op_count)
  );

  always #5 clk = ~clk;

  // behavioural ALU: completion two cycles after the opcode pulse
  logic               alu_en;
  logic               force_cmp;
  logic [1:0]         d1, d2;
  logic signed [127:0] sa, sb;

  always_ff @(posedge clk) begin
    if (reset) begin
      d1 <= 2'd0;
      d2 <= 2'd0;
    end else begin
      d1 <= alu_op;
      d2 <= d1;
    end
  end

  assign sa = {{64{alu_a[63]}}, alu_a};
  assign sb = {{64{alu_b[63]}}, alu_b};

  always_comb begin
    alu_completed = (alu_en && d2 != 2'd0) || force_cmp;
    case (d2)
      2'd1:    alu_c = sa + sb;
      2'd2:    alu_c = sa * sb;
      default: alu_c = '0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // accept in cycle t, leave the bench sitting in cycle t+4 with the response checked
  task automatic run_to_resp(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic [1:0] op, input logic [127:0] exp);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    chk({tag, "_req_ready_t"}, 128'(bus.req_ready), 128'd1);
    tick;
    bus.req_valid = 1'b0;
    chk({tag, "_alu_op_t1"}, 128'(alu_op), 128'(op));
    chk({tag, "_req_ready_t1"}, 128'(bus.req_ready), 128'd0);
    tick;
    chk({tag, "_alu_op_t2"}, 128'(alu_op), 128'd0);
    tick;
    chk({tag, "_rsp_valid_t3"}, 128'(bus.rsp_valid), 128'd0);
    tick;
    chk({tag, "_rsp_valid_t4"}, 128'(bus.rsp_valid), 128'd1);
    chk({tag, "_rsp_data"}, bus.rsp_data, exp);
    chk({tag, "_rsp_err"}, 128'(bus.rsp_err), 128'd0);
  endtask

  task automatic finish_rsp(input string tag, input logic [15:0] exp_cnt);
    tick;
    chk({tag, "_rsp_valid_done"}, 128'(bus.rsp_valid), 128'd0);
    chk({tag, "_req_ready_done"}, 128'(bus.req_ready), 128'd1);
    chk({tag, "_op_count"}, 128'(op_count), 128'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    alu_en        = 1'b1;
    force_cmp     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = 2'd0;
    bus.rsp_ready = 1'b1;
    tick;
    tick;

    chk("rst_req_ready", 128'(bus.req_ready), 128'd1);
    chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    chk("rst_rsp_data",  bus.rsp_data, 128'd0);
    chk("rst_rsp_err",   128'(bus.rsp_err), 128'd0);
    chk("rst_alu_a",     128'(alu_a), 128'd0);
    chk("rst_alu_op",    128'(alu_op), 128'd0);
    chk("rst_busy",      128'(busy), 128'd0);
    chk("rst_op_count",  128'(op_count), 128'd0);
    reset = 1'b0;
    tick;

    // add 5 + -7 = -2
    run_to_resp("add", 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 2'd1,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    finish_rsp("add", 16'd1);

    // mul 3 * -4 = -12
    run_to_resp("mul_neg", 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 2'd2,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF4);
    finish_rsp("mul_neg", 16'd2);

    // mul 2^62 * 4 = 2^64
    run_to_resp("mul_big", 64'h4000_0000_0000_0000, 64'd4, 2'd2,
                128'h0000_0000_0000_0001_0000_0000_0000_0000);
    finish_rsp("mul_big", 16'd3);

    // reserved op issues normally, ALU returns zero
    run_to_resp("op3", 64'd9, 64'd9, 2'd3, 128'd0);
    finish_rsp("op3", 16'd4);

    // nop answers in t+1 without touching the ALU
    bus.req_valid = 1'b1;
    bus.req_a     = 64'd77;
    bus.req_op    = 2'd0;
    tick;
    bus.req_valid = 1'b0;
    chk("nop_rsp_valid", 128'(bus.rsp_valid), 128'd1);
    chk("nop_rsp_data",  bus.rsp_data, 128'd0);
    chk("nop_rsp_err",   128'(bus.rsp_err), 128'd0);
    chk("nop_alu_op",    128'(alu_op), 128'd0);
    chk("nop_alu_a",     128'(alu_a), 128'd9);
    finish_rsp("nop", 16'd5);

    // backpressure: response held five cycles
    bus.rsp_ready = 1'b0;
    run_to_resp("bp", 64'd100, 64'd23, 2'd1, 128'd123);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 128'(bus.rsp_valid), 128'd1);
      chk("bp_hold_data",  bus.rsp_data, 128'd123);
      chk("bp_hold_ready", 128'(bus.req_ready), 128'd0);
      chk("bp_hold_op",    128'(alu_op), 128'd0);
      tick;
    end
    chk("bp_still_valid", 128'(bus.rsp_valid), 128'd1);
    bus.rsp_ready = 1'b1;
    finish_rsp("bp", 16'd6);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    tick;
    bus.req_valid = 1'b0;
    chk("bp_next_accept", 128'(bus.rsp_valid), 128'd1);
    finish_rsp("bp_next", 16'd7);

    // timeout: ALU stays silent for 8 WAIT cycles
    alu_en        = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_a     = 64'd1;
    bus.req_b     = 64'd2;
    bus.req_op    = 2'd1;
    tick;
    bus.req_valid = 1'b0;
    chk("to_issue_op", 128'(alu_op), 128'd1);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("to_wait_valid", 128'(bus.rsp_valid), 128'd0);
      chk("to_wait_busy",  128'(busy), 128'd1);
    end
    tick;
    chk("to_rsp_valid", 128'(bus.rsp_valid), 128'd1);
    chk("to_rsp_err",   128'(bus.rsp_err), 128'd1);
    chk("to_rsp_data",  bus.rsp_data, 128'd0);
    finish_rsp("to", 16'd7);
    alu_en    = 1'b1;
    force_cmp = 1'b1;
    tick;
    force_cmp = 1'b0;
    chk("spur_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    chk("spur_busy",      128'(busy), 128'd0);
    chk("spur_ready",     128'(bus.req_ready), 128'd1);

    // reset one cycle after ISSUE abandons the transaction
    bus.req_valid = 1'b1;
    bus.req_a     = 64'd50;
    bus.req_b     = 64'd60;
    bus.req_op    = 2'd1;
    tick;
    bus.req_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mrst_req_ready", 128'(bus.req_ready), 128'd1);
    chk("mrst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    chk("mrst_alu_a",     128'(alu_a), 128'd0);
    chk("mrst_alu_b",     128'(alu_b), 128'd0);
    chk("mrst_busy",      128'(busy), 128'd0);
    chk("mrst_op_count",  128'(op_count), 128'd0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("mrst_no_rsp", 128'(bus.rsp_valid), 128'd0);
    end
    run_to_resp("post_rst", 64'd1, 64'd1, 2'd1, 128'd2);
    finish_rsp("post_rst", 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
